// File: rtl/drs_pkg.sv
// Shared constants and types for the DRS4 serial shift-register sequencer.
// Address codes drive the DRS A[3:0] pins for each register access.
package drs_pkg;

  localparam logic [3:0] ADR_TRANSPARENT = 4'b1010;
  localparam logic [3:0] ADR_READ_SR     = 4'b1011;
  localparam logic [3:0] ADR_CONFIG      = 4'b1100;
  localparam logic [3:0] ADR_WRITE_SR    = 4'b1101;
  localparam logic [3:0] ADR_STANDBY     = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_LOAD  = 3'd3,
    ST_GAP   = 3'd4,
    ST_HOLD  = 3'd5,
    ST_DONE  = 3'd6
  } sr_state_e;

  typedef enum logic [1:0] {
    PH_CONFIG = 2'd0,
    PH_WSR    = 2'd1,
    PH_READ   = 2'd2
  } sr_phase_e;

  function automatic logic [3:0] phase_addr(input sr_phase_e ph);
    logic [3:0] a;
    case (ph)
      PH_CONFIG: a = ADR_CONFIG;
      PH_WSR:    a = ADR_WRITE_SR;
      PH_READ:   a = ADR_READ_SR;
      default:   a = ADR_STANDBY;
    endcase
    return a;
  endfunction

  function automatic logic [3:0] idle_addr(input logic transp);
    return transp ? ADR_TRANSPARENT : ADR_STANDBY;
  endfunction

endpackage

// File: rtl/drs_sr_shifter.sv
// Generic W-bit shifter: parallel load, MSB-first serial out, serial in at the LSB,
// plus a bit counter that flags the last shift of an i_len-bit transfer.
module drs_sr_shifter #(
  parameter int W  = 10,
  parameter int CW = $clog2(W + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic [W-1:0]  i_load_data,
  input  logic          i_shift,
  input  logic          i_sin,
  input  logic [CW-1:0] i_len,
  output logic          o_sout,
  output logic [W-1:0]  o_data,
  output logic          o_last
);

  logic [W-1:0]  r_data;
  logic [CW-1:0] r_cnt;

  // Load wins over shift so a new phase always starts from a clean word and count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_data <= i_load_data;
      r_cnt  <= '0;
    end else if (i_shift) begin
      r_data <= {r_data[W-2:0], i_sin};
      r_cnt  <= r_cnt + CW'(1);
    end
  end

  assign o_sout = r_data[W-1];
  assign o_data = r_data;
  assign o_last = (r_cnt == (i_len - CW'(1)));

endmodule

// File: rtl/drs_sr_sequencer.sv
// Arbitrates configuration writes and stop-cell reads onto the DRS4 serial
// register port, sequencing address setup, SRCLK enables, RSRLOAD and hold.
module drs_sr_sequencer
  import drs_pkg::*;
#(
  parameter int SETUP_CYCLES = 2,
  parameter int STOP_BITS    = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cfg_req_i,
  input  logic [7:0]           drs_config_i,
  input  logic [7:0]           chn_config_i,
  input  logic                 stop_rd_req_i,
  input  logic                 transp_mode_i,
  input  logic                 drs_srout_i,
  output logic [3:0]           drs_addr_o,
  output logic                 drs_srclk_en_o,
  output logic                 drs_srin_o,
  output logic                 drs_rsrload_o,
  output logic [STOP_BITS-1:0] stop_cell_o,
  output logic                 cfg_done_o,
  output logic                 stop_done_o,
  output logic                 busy_o,
  output logic [2:0]           dbg_state_o
);

  localparam int SH_W  = (STOP_BITS > 8) ? STOP_BITS : 8;
  localparam int LEN_W = $clog2(SH_W + 1);
  localparam int TMR_W = $clog2(SETUP_CYCLES + 2);

  // Write bytes sit at the top of the shifter so they leave MSB first.
  function automatic logic [SH_W-1:0] wr_word(input logic [7:0] b);
    return SH_W'(b) << (SH_W - 8);
  endfunction

  sr_state_e          r_state;
  sr_phase_e          r_phase;
  logic [TMR_W-1:0]   r_tmr;
  logic               r_cfg_pend;
  logic               r_rd_pend;
  logic [7:0]         r_cfg_byte;
  logic [7:0]         r_chn_byte;
  logic [3:0]         r_addr;
  logic               r_srin;
  logic [STOP_BITS-1:0] r_stop_cell;

  sr_state_e          w_state_nx;
  sr_phase_e          w_phase_nx;
  logic [TMR_W-1:0]   w_tmr_nx;
  logic               w_sh_load;
  logic [SH_W-1:0]    w_sh_data;
  logic               w_sh_shift;
  logic               w_sh_sout;
  logic [SH_W-1:0]    w_sh_q;
  logic               w_sh_last;
  logic [LEN_W-1:0]   w_sh_len;
  logic               w_busy;
  logic               w_cfg_running;
  logic               w_rd_running;
  logic               w_cfg_acc;
  logic               w_rd_acc;
  logic               w_cfg_want;
  logic               w_rd_want;
  logic               w_launch_cfg;
  logic               w_launch_rd;
  logic [7:0]         w_cfg_byte_now;

  // Requests are single-cycle pulses with no ready: an accepted pulse latches into
  // a 1-deep pending flag (or launches at once); a pulse for a sequence that is
  // already pending or running is discarded.
  assign w_busy        = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign w_cfg_running = w_busy && (r_phase != PH_READ);
  assign w_rd_running  = w_busy && (r_phase == PH_READ);
  assign w_cfg_acc     = cfg_req_i && !r_cfg_pend && !w_cfg_running;
  assign w_rd_acc      = stop_rd_req_i && !r_rd_pend && !w_rd_running;
  assign w_cfg_want    = r_cfg_pend || w_cfg_acc;
  assign w_rd_want     = r_rd_pend || w_rd_acc;
  assign w_cfg_byte_now = r_cfg_pend ? r_cfg_byte : drs_config_i;
  assign w_sh_len      = (r_phase == PH_READ) ? LEN_W'(STOP_BITS) : LEN_W'(8);

  always_comb begin
    w_state_nx   = r_state;
    w_phase_nx   = r_phase;
    w_tmr_nx     = r_tmr;
    w_sh_load    = 1'b0;
    w_sh_data    = '0;
    w_sh_shift   = 1'b0;
    w_launch_cfg = 1'b0;
    w_launch_rd  = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_cfg_want) begin
          w_state_nx   = ST_SETUP;
          w_phase_nx   = PH_CONFIG;
          w_tmr_nx     = '0;
          w_sh_load    = 1'b1;
          w_sh_data    = wr_word(w_cfg_byte_now);
          w_launch_cfg = 1'b1;
        end else if (w_rd_want) begin
          w_state_nx  = ST_SETUP;
          w_phase_nx  = PH_READ;
          w_tmr_nx    = '0;
          w_sh_load   = 1'b1;
          w_launch_rd = 1'b1;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (r_tmr == TMR_W'(SETUP_CYCLES - 1)) begin
          w_tmr_nx   = '0;
          w_state_nx = (r_phase == PH_READ) ? ST_LOAD : ST_SHIFT;
        end else begin
          w_tmr_nx = r_tmr + TMR_W'(1);
        end
      end
      ST_LOAD: w_state_nx = ST_GAP;
      ST_GAP:  w_state_nx = ST_SHIFT;
      ST_SHIFT: begin
        w_sh_shift = 1'b1;
        if (w_sh_last) begin
          w_state_nx = ST_HOLD;
          w_tmr_nx   = '0;
        end
      end
      ST_HOLD: begin
        if (r_tmr == TMR_W'(SETUP_CYCLES)) begin
          w_tmr_nx = '0;
          if (r_phase == PH_CONFIG) begin
            w_state_nx = ST_SETUP;
            w_phase_nx = PH_WSR;
            w_sh_load  = 1'b1;
            w_sh_data  = wr_word(r_chn_byte);
          end else begin
            w_state_nx = ST_DONE;
          end
        end else begin
          w_tmr_nx = r_tmr + TMR_W'(1);
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_phase    <= PH_CONFIG;
      r_tmr      <= '0;
      r_cfg_pend <= 1'b0;
      r_rd_pend  <= 1'b0;
      r_cfg_byte <= '0;
      r_chn_byte <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_phase    <= w_phase_nx;
      r_tmr      <= w_tmr_nx;
      r_cfg_pend <= (r_cfg_pend || w_cfg_acc) && !w_launch_cfg;
      r_rd_pend  <= (r_rd_pend || w_rd_acc) && !w_launch_rd;
      if (w_cfg_acc) begin
        r_cfg_byte <= drs_config_i;
        r_chn_byte <= chn_config_i;
      end
    end
  end

  // Address moves only when a phase enters SETUP or the sequencer returns to IDLE.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr <= ADR_STANDBY;
    end else if ((w_state_nx == ST_SETUP) && (r_state != ST_SETUP)) begin
      r_addr <= phase_addr(w_phase_nx);
    end else if (w_state_nx == ST_IDLE) begin
      r_addr <= idle_addr(transp_mode_i);
    end
  end

  // SRIN lags the enable by one register to line up with the ODDR pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_srin      <= 1'b0;
      r_stop_cell <= '0;
    end else begin
      r_srin <= (r_state == ST_SHIFT) && (r_phase != PH_READ) && w_sh_sout;
      if ((r_state == ST_HOLD) && (w_state_nx == ST_DONE) && (r_phase == PH_READ))
        r_stop_cell <= w_sh_q[STOP_BITS-1:0];
    end
  end

  drs_sr_shifter #(
    .W  (SH_W),
    .CW (LEN_W)
  ) u_shifter (
    .i_clk       (clock),
    .i_rst       (reset),
    .i_load      (w_sh_load),
    .i_load_data (w_sh_data),
    .i_shift     (w_sh_shift),
    .i_sin       (drs_srout_i),
    .i_len       (w_sh_len),
    .o_sout      (w_sh_sout),
    .o_data      (w_sh_q),
    .o_last      (w_sh_last)
  );

  assign drs_addr_o     = r_addr;
  assign drs_srclk_en_o = (r_state == ST_SHIFT);
  assign drs_srin_o     = r_srin;
  assign drs_rsrload_o  = (r_state == ST_LOAD);
  assign stop_cell_o    = r_stop_cell;
  assign cfg_done_o     = (r_state == ST_DONE) && (r_phase != PH_READ);
  assign stop_done_o    = (r_state == ST_DONE) && (r_phase == PH_READ);
  assign busy_o         = w_busy;
  assign dbg_state_o    = r_state;

endmodule

// File: tb/tb_drs_sr_sequencer.sv
// Directed bench for drs_sr_sequencer with a behavioural DRS4 shift-register model
// clocked on the falling edge of each SRCLK pulse.
module tb_drs_sr_sequencer;
  import drs_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_req_i = 1'b0;
  logic       stop_rd_req_i = 1'b0;
  logic       transp_mode_i = 1'b0;
  logic [7:0] drs_config_i = 8'h00;
  logic [7:0] chn_config_i = 8'h00;
  logic       drs_srout_i;
  logic [3:0] drs_addr_o;
  logic       drs_srclk_en_o;
  logic       drs_srin_o;
  logic       drs_rsrload_o;
  logic [9:0] stop_cell_o;
  logic       cfg_done_o;
  logic       stop_done_o;
  logic       busy_o;
  logic [2:0] dbg_state_o;

  always #5 clock = ~clock;

  drs_sr_sequencer #(.SETUP_CYCLES(2), .STOP_BITS(10)) dut (
    .clock          (clock),
    .reset          (reset),
    .cfg_req_i      (cfg_req_i),
    .drs_config_i   (drs_config_i),
    .chn_config_i   (chn_config_i),
    .stop_rd_req_i  (stop_rd_req_i),
    .transp_mode_i  (transp_mode_i),
    .drs_srout_i    (drs_srout_i),
    .drs_addr_o     (drs_addr_o),
    .drs_srclk_en_o (drs_srclk_en_o),
    .drs_srin_o     (drs_srin_o),
    .drs_rsrload_o  (drs_rsrload_o),
    .stop_cell_o    (stop_cell_o),
    .cfg_done_o     (cfg_done_o),
    .stop_done_o    (stop_done_o),
    .busy_o         (busy_o),
    .dbg_state_o    (dbg_state_o)
  );

  // ---------------- DRS model and event monitor ----------------
  logic       en_d = 1'b0;
  logic [7:0] m_cfg = 8'h00;
  logic [7:0] m_wsr = 8'h00;
  logic [9:0] m_rd = 10'h000;
  logic [9:0] stop_val = 10'h000;
  logic [9:0] last_stop = 10'h000;
  int cyc = 0;
  int t0 = 0;
  int n_pulse = 0;
  int n_viol = 0;
  int n_cfg_done = 0;
  int n_stop_done = 0;
  int last_cfg_cyc = 0;
  int last_stop_cyc = 0;

  assign drs_srout_i = m_rd[9];

  always @(posedge clock) begin
    cyc  <= cyc + 1;
    en_d <= drs_srclk_en_o;
  end

  always @(negedge clock) begin
    if (drs_rsrload_o)
      m_rd <= stop_val;
    else if (en_d && drs_addr_o == ADR_READ_SR)
      m_rd <= {m_rd[8:0], 1'b0};
    if (en_d) begin
      n_pulse <= n_pulse + 1;
      if (drs_addr_o == ADR_CONFIG)   m_cfg <= {m_cfg[6:0], drs_srin_o};
      if (drs_addr_o == ADR_WRITE_SR) m_wsr <= {m_wsr[6:0], drs_srin_o};
    end
    if ((drs_srclk_en_o && (drs_rsrload_o || !busy_o)) ||
        ((cfg_done_o || stop_done_o) && busy_o))
      n_viol <= n_viol + 1;
    if (cfg_done_o) begin
      n_cfg_done   <= n_cfg_done + 1;
      last_cfg_cyc <= cyc;
    end
    if (stop_done_o) begin
      n_stop_done   <= n_stop_done + 1;
      last_stop_cyc <= cyc;
      last_stop     <= stop_cell_o;
    end
  end

  // ---------------- scoreboard helpers ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic go_to(input int c);
    int guard;
    guard = 0;
    while (cyc < t0 + c && guard < 1000) begin
      step();
      guard++;
    end
  endtask

  typedef struct {
    logic       do_cfg;
    logic       do_rd;
    logic [7:0] drs_cfg;
    logic [7:0] chn_cfg;
    logic [9:0] stop_v;
    logic [7:0] exp_cfg;
    logic [7:0] exp_wsr;
    logic [9:0] exp_stop;
    int         exp_cfg_at;
    int         exp_stop_at;
    int         exp_pulses;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v, input int idx);
    int p0, v0, c0, s0;
    step();
    stop_val     = v.stop_v;
    drs_config_i = v.drs_cfg;
    chn_config_i = v.chn_cfg;
    p0 = n_pulse; v0 = n_viol; c0 = n_cfg_done; s0 = n_stop_done;
    t0 = cyc;
    cfg_req_i     = v.do_cfg;
    stop_rd_req_i = v.do_rd;
    step();
    cfg_req_i     = 1'b0;
    stop_rd_req_i = 1'b0;
    drs_config_i  = ~v.drs_cfg;
    chn_config_i  = ~v.chn_cfg;
    chk($sformatf("v%0d_busy_c1", idx), busy_o, 1);
    go_to(60);
    if (v.do_cfg) begin
      chk($sformatf("v%0d_cfg_reg", idx), m_cfg, v.exp_cfg);
      chk($sformatf("v%0d_wsr_reg", idx), m_wsr, v.exp_wsr);
      chk($sformatf("v%0d_cfg_done_cyc", idx), last_cfg_cyc - t0, v.exp_cfg_at);
    end
    chk($sformatf("v%0d_cfg_done_cnt", idx), n_cfg_done - c0, v.do_cfg ? 1 : 0);
    if (v.do_rd) begin
      chk($sformatf("v%0d_stop_cell", idx), last_stop, v.exp_stop);
      chk($sformatf("v%0d_stop_done_cyc", idx), last_stop_cyc - t0, v.exp_stop_at);
    end
    chk($sformatf("v%0d_stop_done_cnt", idx), n_stop_done - s0, v.do_rd ? 1 : 0);
    chk($sformatf("v%0d_pulses", idx), n_pulse - p0, v.exp_pulses);
    chk($sformatf("v%0d_protocol", idx), n_viol - v0, 0);
    chk($sformatf("v%0d_idle_busy", idx), busy_o, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int c0, s0;
    vecs[0] = '{1'b1, 1'b0, 8'hFA, 8'h55, 10'h000, 8'hFA, 8'h55, 10'h000, 27, 0, 16};
    vecs[1] = '{1'b0, 1'b1, 8'h00, 8'h00, 10'h0EE, 8'h00, 8'h00, 10'h0EE, 0, 18, 10};
    vecs[2] = '{1'b1, 1'b1, 8'h81, 8'h3C, 10'h2A5, 8'h81, 8'h3C, 10'h2A5, 27, 45, 26};
    vecs[3] = '{1'b0, 1'b1, 8'h00, 8'h00, 10'h3FF, 8'h00, 8'h00, 10'h3FF, 0, 18, 10};
    vecs[4] = '{1'b1, 1'b0, 8'h00, 8'hFF, 10'h000, 8'h00, 8'hFF, 10'h000, 27, 0, 16};
    vecs[5] = '{1'b0, 1'b1, 8'h00, 8'h00, 10'h200, 8'h00, 8'h00, 10'h200, 0, 18, 10};

    // Reset values
    step(); step(); step();
    chk("rst_addr", drs_addr_o, ADR_STANDBY);
    chk("rst_outs", {drs_srclk_en_o, drs_srin_o, drs_rsrload_o, cfg_done_o, stop_done_o, busy_o}, 0);
    chk("rst_stop_cell", stop_cell_o, 10'h000);
    reset = 1'b0;
    step();
    chk("post_rst_busy", busy_o, 0);

    // Idle address follows transp_mode_i
    transp_mode_i = 1'b1;
    step(); step();
    chk("idle_addr_transp", drs_addr_o, ADR_TRANSPARENT);
    transp_mode_i = 1'b0;
    step(); step();
    chk("idle_addr_standby", drs_addr_o, ADR_STANDBY);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Read with transp toggle mid-sequence; stop_cell holds until DONE
    step();
    stop_val = 10'h155;
    s0 = n_stop_done;
    t0 = cyc;
    stop_rd_req_i = 1'b1;
    step();
    stop_rd_req_i = 1'b0;
    go_to(5);
    transp_mode_i = 1'b1;
    go_to(10);
    chk("rd_addr_during_shift", drs_addr_o, ADR_READ_SR);
    go_to(16);
    chk("rd_stop_cell_held", stop_cell_o, vecs[5].exp_stop);
    go_to(18);
    chk("rd_stop_done_c18", stop_done_o, 1);
    chk("rd_stop_cell_c18", stop_cell_o, 10'h155);
    go_to(20);
    chk("rd_idle_addr_transp", drs_addr_o, ADR_TRANSPARENT);
    transp_mode_i = 1'b0;
    go_to(22);
    chk("rd_idle_addr_standby", drs_addr_o, ADR_STANDBY);
    chk("rd_done_cnt", n_stop_done - s0, 1);

    // Duplicate config request dropped, request in DONE cycle accepted
    step();
    drs_config_i = 8'hA5;
    chn_config_i = 8'h5A;
    c0 = n_cfg_done;
    t0 = cyc;
    cfg_req_i = 1'b1;
    step();
    cfg_req_i = 1'b0;
    go_to(5);
    drs_config_i = 8'h11;
    chn_config_i = 8'h22;
    cfg_req_i = 1'b1;
    step();
    cfg_req_i = 1'b0;
    go_to(27);
    chk("dup_done_c27", cfg_done_o, 1);
    chk("dup_busy_c27", busy_o, 0);
    chk("dup_state_c27", dbg_state_o, ST_DONE);
    chk("dup_cfg_reg", m_cfg, 8'hA5);
    chk("dup_wsr_reg", m_wsr, 8'h5A);
    drs_config_i = 8'hC3;
    chn_config_i = 8'h3C;
    cfg_req_i = 1'b1;
    step();
    cfg_req_i = 1'b0;
    drs_config_i = 8'h00;
    chn_config_i = 8'h00;
    go_to(70);
    chk("done_req_cnt", n_cfg_done - c0, 2);
    chk("done_req_cyc", last_cfg_cyc - t0, 54);
    chk("done_req_cfg_reg", m_cfg, 8'hC3);
    chk("done_req_wsr_reg", m_wsr, 8'h3C);

    // Reset during CONFIG SHIFT bit 4
    step();
    drs_config_i = 8'hF0;
    chn_config_i = 8'h0F;
    c0 = n_cfg_done;
    t0 = cyc;
    cfg_req_i = 1'b1;
    step();
    cfg_req_i = 1'b0;
    go_to(7);
    chk("mid_state_shift", dbg_state_o, ST_SHIFT);
    chk("mid_en", drs_srclk_en_o, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_addr", drs_addr_o, ADR_STANDBY);
    chk("mid_rst_outs", {drs_srclk_en_o, drs_srin_o, drs_rsrload_o, cfg_done_o, stop_done_o, busy_o}, 0);
    go_to(40);
    chk("mid_rst_no_done", n_cfg_done - c0, 0);
    run_vec(vecs[0], 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/drs_sr_sequencer.md
# drs_sr_sequencer

Sequences the DRS4 serial shift-register interface (address, SRCLK enable, SRIN, RSRLOAD, SROUT) between two requesters: chip configuration (CONFIG and WRITE_SR registers) and stop-cell readout (READ_SR). Sits between `drs` control logic and the SRCLK ODDR. Arbitrates requests, holds pending requests, and returns the 10-bit stop cell with a done strobe.

## Interface
Parameters
- `SETUP_CYCLES`, 2, address setup cycles before the first SRCLK; hold is `SETUP_CYCLES+1`.
- `STOP_BITS`, 10, stop-cell width.

Ports
- `clock` in 1: 33 MHz system clock.
- `reset` in 1: synchronous, active-high.
- `cfg_req_i` in 1: one-cycle pulse requesting a configuration write.
- `drs_config_i` in 8: CONFIG register value; top 3 bits set by the caller.
- `chn_config_i` in 8: WRITE_SR value.
- `stop_rd_req_i` in 1: one-cycle pulse requesting a stop-cell read.
- `transp_mode_i` in 1: idle address select; 1 = TRANSPARENT (4'b1010), 0 = STANDBY (4'b1111).
- `drs_srout_i` in 1: DRS SROUT.
- `drs_addr_o` out 4: DRS address.
- `drs_srclk_en_o` out 1: ODDR enable; the pulse appears one cycle later.
- `drs_srin_o` out 1: DRS SRIN.
- `drs_rsrload_o` out 1: read shift-register load.
- `stop_cell_o` out 10: last stop cell read.
- `cfg_done_o` out 1: one-cycle pulse.
- `stop_done_o` out 1: one-cycle pulse; `stop_cell_o` is valid from this cycle.
- `busy_o` out 1: sequence in progress.

## Operation
- Reset values:
  - `drs_addr_o`: STANDBY.
  - All other outputs: 0, including `stop_cell_o`.
  - Pending flags: cleared.
- Reset mid-sequence: abort immediately, return to IDLE, no done pulse.
- States:
  - IDLE: address = idle address per `transp_mode_i`.
  - SETUP
  - SHIFT
  - LOAD
  - GAP
  - HOLD
  - DONE
- Phase list:
  - Config sequence: CONFIG phase (addr 4'b1100, 8 bits of `drs_config_i`), then WSR phase (addr 4'b1101, 8 bits of `chn_config_i`).
  - Read sequence: READ_SR phase (addr 4'b1011).
- Write phase order:
  - SETUP for `SETUP_CYCLES` cycles.
  - SHIFT for 8 cycles with `drs_srclk_en_o`=1.
  - HOLD for `SETUP_CYCLES+1` cycles.
- Read phase order:
  - SETUP for `SETUP_CYCLES` cycles.
  - LOAD for 1 cycle with `drs_rsrload_o`=1.
  - GAP for 1 cycle.
  - SHIFT for `STOP_BITS` cycles.
  - HOLD for `SETUP_CYCLES+1` cycles.
- Data for write phases is captured at request acceptance. Later input changes do not affect an accepted sequence.
- Writes are MSB first. `drs_srin_o` carries bit k during the cycle after the k-th `srclk_en` cycle, i.e. during the SRCLK pulse. This is a one-register delay matching the ODDR latency.
- Reads: `drs_srout_i` is sampled on each rising edge that starts an SRCLK pulse (the edge after each `srclk_en` cycle). It is shifted into an internal register MSB first, and the first sample is bit 9. `stop_cell_o` updates only at DONE.
- Arbitration:
  - Each request sets a 1-deep pending flag.
  - Duplicate requests while pending or while that sequence is running are dropped.
  - In IDLE, config has priority over read when both are pending.
  - A request arriving in the DONE cycle is accepted normally.
- DONE: one cycle. The relevant done pulse is asserted and `busy_o` is 0. The next pending sequence starts the following cycle.

## Timing
- Request sampled at edge 0; `busy_o`=1 from cycle 1.
- Config sequence, with S=`SETUP_CYCLES`:
  - 2·(S+8+S+1) = 26 busy cycles with default S.
  - `cfg_done_o` in cycle 27.
- Read sequence: S+1+1+10+S+1 = 17 busy cycles; `stop_done_o` in cycle 18.
- `drs_addr_o` changes only on entry to SETUP or on return to IDLE. It is stable from S cycles before the first SRCLK pulse through S cycles after the last pulse.
- `drs_rsrload_o` never overlaps `drs_srclk_en_o`. `drs_srclk_en_o` is never high outside SHIFT.

## Structure
- Shared package `drs_pkg`:
  - Address constants ADR_TRANSPARENT, ADR_READ_SR, ADR_WRITE_SR, ADR_CONFIG, ADR_STANDBY.
  - State enum.
- Sub-module `drs_sr_shifter`: a generic N-bit parallel-load/serial-out and serial-in shifter with bit counter, instantiated once. The FSM owns phase sequencing.

## Test plan
- Config: `drs_config_i`=0xFA, `chn_config_i`=0x55, `cfg_req_i` pulse.
  - Negedge-SRCLK model registers read 0xFA (addr 4'b1100) and 0x55 (addr 4'b1101).
  - `cfg_done_o` in cycle 27; exactly 16 SRCLK pulses.
- Stop read: DRS model loads 10'h0EE on RSRLOAD.
  - `stop_cell_o`=10'h0EE at `stop_done_o`, cycle 18.
  - Exactly 10 pulses.
- Simultaneous `cfg_req_i` and `stop_rd_req_i`:
  - Config runs first; `stop_done_o` follows 1+17 cycles after `cfg_done_o`.
  - Second `cfg_req_i` during config is dropped.
- `reset` asserted in CONFIG SHIFT bit 4:
  - Next cycle all outputs at reset values, no done pulse.
  - A new request then completes correctly.
- Idle address: toggling `transp_mode_i` in IDLE gives addr 4'b1010 / 4'b1111. A toggle during a sequence has no effect until return to IDLE.
